mseq_sync: RTL
==============

MSEQ_SYNC -- requirements
Module: mseq_sync

Interface
REQ-001 Parameter PERIOD, 31: m-sequence length in chips, which is also the correlation-peak spacing in clk cycles.
REQ-002 Parameter THR_HI, 56: corr at or above this value is a positive peak (bit 1).
REQ-003 Parameter THR_LO, 6: corr at or below this value is a negative peak (bit 0).
REQ-004 Parameter LOCK_CNT, 3: number of consecutive on-time peaks, anchor included, required to lock.
REQ-005 Parameter MISS_MAX, 2: number of consecutive missed peaks that drops lock.
REQ-006 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port corr, input, 8: correlator output, one sample per clk, nominal range 0..62.
REQ-009 Port peak, output, 1: one-cycle strobe when any sample is classified as a peak.
REQ-010 Port locked, output, 1: high while in LOCK.
REQ-011 Port bit_valid, output, 1: one-cycle strobe marking a decoded symbol.
REQ-012 Port bit_out, output, 1: decoded symbol value; meaningful only when bit_valid is high.
REQ-013 Port miss, output, 1: one-cycle strobe when a peak is missed while locked.
REQ-014 Port phase, output, 5: current chip phase, range 0..PERIOD-1.

Function
REQ-015 Classification (combinational): POS when corr>=THR_HI; NEG when corr<=THR_LO; NONE otherwise. Values above 62 classify as POS.
REQ-016 All outputs SHALL be registered, appearing one clk after the corr sample that causes them.
REQ-017 peak SHALL follow the classification (POS or NEG) in every state, including off-schedule samples.
REQ-018 States SHALL be SEARCH, VERIFY and LOCK.
REQ-019 SEARCH: on a POS or NEG sample (the anchor), go to VERIFY with phase<=0 and hits<=1; otherwise phase holds at 0.
REQ-020 phase SHALL increment by 1 each cycle in VERIFY and LOCK, and wrap to 0 on the check cycle (the cycle where phase==PERIOD-1), i.e. exactly PERIOD cycles after the anchor.
REQ-021 Peaks on non-check cycles in VERIFY or LOCK SHALL NOT affect state, hits or miss count.
REQ-022 VERIFY check cycle with a peak (either polarity): hits++; when hits reaches LOCK_CNT, go to LOCK with miss count 0.
REQ-023 VERIFY check cycle with NONE: go to SEARCH with hits<=0 and phase<=0.
REQ-024 LOCK check cycle with a peak: bit_valid=1, bit_out=1 for POS and 0 for NEG, miss count<=0.
REQ-025 LOCK check cycle with NONE: miss=1, bit_valid=0, miss count++; when the count reaches MISS_MAX, go to SEARCH (phase 0, counters 0, locked drops on the next cycle).
REQ-026 hits and miss counters SHALL saturate and never wrap.
REQ-027 A LOCK-to-SEARCH transition SHALL NOT use the same sample as a new anchor; re-acquisition begins with the next sample.

Reset
REQ-028 When rst_n=0 at a clk edge: state SEARCH, phase 0, hits 0, miss count 0, and peak, locked, bit_valid, bit_out, miss all 0.
REQ-029 Reset SHALL override every simultaneous event, including mid-VERIFY and mid-LOCK; sampling resumes on the first cycle after release.

Structure
REQ-030 Package mseq_pkg SHALL hold the PERIOD, THR_HI and THR_LO defaults, the state enum (SEARCH/VERIFY/LOCK) and the classification enum (NONE/POS/NEG).
REQ-031 One sub-module, mseq_peak_cls, SHALL implement the combinational threshold classifier; the FSM, phase counter and hit/miss counters stay in mseq_sync.
REQ-032 Estimated size: 150-250 lines of RTL.

Verification
REQ-033 Acquire: corr=62 at cycle 0, 31, 62, other samples 31 -> locked=1 one cycle after cycle 62; phase=0 in that same cycle.
REQ-034 Decode: after lock, check-cycle samples 62,0,0,62 -> bit_valid strobes every 31 cycles with bit_out 1,0,0,1; peak strobes in step.
REQ-035 False anchor: corr=60 at cycle 0, then corr=31 at cycle 31 -> return to SEARCH; locked never asserts; phase=0.
REQ-036 Loss: locked; two consecutive check samples corr=31 -> miss strobes twice, locked=0 after the second; a single miss followed by a 62 keeps locked=1.
REQ-037 Off-schedule peak: locked; corr=62 at phase 10 -> peak=1, bit_valid=0, phase sequence undisturbed.
REQ-038 Reset mid-LOCK: rst_n=0 for 1 cycle coinciding with a check-cycle corr=62 -> all outputs 0 and no bit_valid; a full LOCK_CNT-peak re-acquisition is required.

Source files
------------

// File: rtl/mseq_pkg.sv
// mseq_pkg: shared defaults and enums for the m-sequence synchroniser.
// Holds PERIOD/THR_HI/THR_LO defaults, FSM state and classifier enums.
package mseq_pkg;

  localparam int PERIOD_D = 31;
  localparam int THR_HI_D = 56;
  localparam int THR_LO_D = 6;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCK
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    POS,
    NEG
  } cls_t;

endpackage

// File: rtl/mseq_peak_cls.sv
// mseq_peak_cls: combinational correlation threshold classifier.
// Ports: corr (8b sample in), cls (NONE/POS/NEG out).
module mseq_peak_cls
  import mseq_pkg::*;
#(
  parameter int THR_HI = THR_HI_D,
  parameter int THR_LO = THR_LO_D
) (
  input  logic [7:0] corr,
  output cls_t       cls
);

  always_comb begin
    cls = NONE;
    if (corr >= 8'(THR_HI)) begin
      cls = POS;
    end else if (corr <= 8'(THR_LO)) begin
      cls = NEG;
    end
  end

endmodule

// File: rtl/mseq_sync.sv
// mseq_sync: peak-spacing synchroniser and symbol decoder.
// Ports: clk, rst_n (sync, active-low), corr in; peak, locked,
// bit_valid, bit_out, miss, phase (all registered) out.
module mseq_sync
  import mseq_pkg::*;
#(
  parameter int PERIOD   = PERIOD_D,
  parameter int THR_HI   = THR_HI_D,
  parameter int THR_LO   = THR_LO_D,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] corr,
  output logic       peak,
  output logic       locked,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       miss,
  output logic [4:0] phase
);

  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [HW-1:0] HIT_MAX = HW'(LOCK_CNT);
  localparam logic [MW-1:0] MIS_MAX = MW'(MISS_MAX);
  localparam logic [4:0] PH_END = 5'(PERIOD - 1);

  cls_t          cls;
  state_t        state;
  logic [HW-1:0] hits;
  logic [MW-1:0] mcnt;
  logic [HW-1:0] hits_inc;
  logic [MW-1:0] mcnt_inc;
  logic          hit;
  logic          chk;

  mseq_peak_cls #(
    .THR_HI(THR_HI),
    .THR_LO(THR_LO)
  ) u_cls (
    .corr(corr),
    .cls (cls)
  );

  assign hit = (cls != NONE);
  assign chk = (phase == PH_END);

  // Counters saturate instead of wrapping.
  assign hits_inc = (hits == HIT_MAX) ? hits : hits + 1'b1;
  assign mcnt_inc = (mcnt == MIS_MAX) ? mcnt : mcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEARCH;
      phase     <= '0;
      hits      <= '0;
      mcnt      <= '0;
      peak      <= 1'b0;
      locked    <= 1'b0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      miss      <= 1'b0;
    end else begin
      peak      <= hit;
      bit_valid <= 1'b0;
      miss      <= 1'b0;
      unique case (state)
        SEARCH: begin
          phase <= '0;
          if (hit) begin
            state <= VERIFY;
            hits  <= HW'(1);
          end
        end
        VERIFY: begin
          if (!chk) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (!hit) begin
              state <= SEARCH;
              hits  <= '0;
            end else begin
              hits <= hits_inc;
              if (hits_inc == HIT_MAX) begin
                state  <= LOCK;
                locked <= 1'b1;
                mcnt   <= '0;
              end
            end
          end
        end
        LOCK: begin
          if (!chk) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (hit) begin
              bit_valid <= 1'b1;
              bit_out   <= (cls == POS);
              mcnt      <= '0;
            end else begin
              miss <= 1'b1;
              mcnt <= mcnt_inc;
              // The dropping sample is NONE, so it never anchors.
              if (mcnt_inc == MIS_MAX) begin
                state  <= SEARCH;
                locked <= 1'b0;
                hits   <= '0;
                mcnt   <= '0;
              end
            end
          end
        end
        default: begin
          state <= SEARCH;
          phase <= '0;
        end
      endcase
    end
  end

endmodule
